// File: rtl/nib_pack_arbiter_if.sv
// Stream bundle between NUM_SRC upstream sources, the nib_pack_arbiter and the packer.
// master = arbiter side, slave = sources/packer side.
interface nib_pack_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SRC    = 4
);
  // Valid/ready: a beat transfers on a rising clk edge where tvalid and tready are both high;
  // a source holds tdata/tkeep/tlast stable while tvalid is high and tready is low.
  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC*8-1:0]          s_axis_tkeep;
  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC-1:0]            s_axis_tlast;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [7:0]                    m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
  modport slave (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/nib_pack_arbiter.sv
// Packet-level round-robin arbiter in front of the nibble packer, with length/tkeep policing.
// Optional NIB_PACK_ARB_OUT_REG_EN: m_axis driven from a 2-entry skid buffer.
module nib_pack_arbiter #(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_SRC    = 4,
  parameter int  MAX_BEATS  = 64,
  localparam int GW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                clk,
  input  logic                aresetn,
  nib_pack_arbiter_if.master  bus,
  output logic [GW-1:0]       grant_id,
  output logic                busy,
  output logic                err_len,
  output logic                err_keep,
  input  logic                err_clr,
  output logic [1:0]          dbg_state
);
  localparam int CW = $clog2(MAX_BEATS);

  typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, PKT = 2'd2} state_t;

  state_t                state_q, state_d;
  logic [GW-1:0]         rr_ptr, winner, cand;
  logic                  found;
  logic [CW-1:0]         beat_cnt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [7:0]            sel_keep;
  logic                  sel_valid, sel_last;
  logic                  cap, pkt_last, beat, keep_bad, up_ready;
  logic [NUM_SRC-1:0]    tready_c;

  // Granted-source mux, constant indices only.
  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == GW'(i)) begin
        sel_data  = bus.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_axis_tkeep[i*8 +: 8];
        sel_valid = bus.s_axis_tvalid[i];
        sel_last  = bus.s_axis_tlast[i];
      end
    end
  end

  // Round-robin search starting just after the last granted source.
  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_SRC);
      if (!found && bus.s_axis_tvalid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign cap      = (beat_cnt == CW'(MAX_BEATS - 1));
  assign pkt_last = sel_last | cap;
  assign keep_bad = !(sel_keep inside {8'd4, 8'd8, 8'd12, 8'd16});
  assign busy     = (state_q == PKT);
  assign dbg_state = state_q;

  always_comb begin
    state_d  = state_q;
    beat     = 1'b0;
    tready_c = '0;
    case (state_q)
      IDLE: if (|bus.s_axis_tvalid) state_d = ARB;
      ARB:  state_d = found ? PKT : IDLE;
      PKT: begin
        for (int i = 0; i < NUM_SRC; i++) tready_c[i] = (grant_id == GW'(i)) & up_ready;
        beat = sel_valid & up_ready;
        if (beat && pkt_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.s_axis_tready = tready_c;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(NUM_SRC - 1);
      beat_cnt <= '0;
      err_len  <= 1'b0;
      err_keep <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB && found) begin
        grant_id <= winner;
        rr_ptr   <= winner;
      end
      if (beat) beat_cnt <= pkt_last ? '0 : beat_cnt + CW'(1);
      // Set is written after clear so a same-cycle set wins.
      if (err_clr) begin
        err_len  <= 1'b0;
        err_keep <= 1'b0;
      end
      if (beat && cap && !sel_last) err_len  <= 1'b1;
      if (beat && keep_bad)         err_keep <= 1'b1;
    end
  end

`ifdef NIB_PACK_ARB_OUT_REG_EN
  localparam int PW = DATA_WIDTH + 9;
  logic [PW-1:0] skid_mem [2];
  logic          wr_ptr, rd_ptr, pop;
  logic [1:0]    count;

  assign up_ready = (count != 2'd2);
  assign pop      = (count != 2'd0) & bus.m_axis_tready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (beat) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(beat) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) skid_mem[wr_ptr] <= {pkt_last, sel_keep, sel_data};
  end

  assign bus.m_axis_tvalid = (count != 2'd0);
  assign bus.m_axis_tlast  = bus.m_axis_tvalid & skid_mem[rd_ptr][PW-1];
  assign bus.m_axis_tkeep  = skid_mem[rd_ptr][DATA_WIDTH +: 8];
  assign bus.m_axis_tdata  = skid_mem[rd_ptr][DATA_WIDTH-1:0];
`else
  assign up_ready          = bus.m_axis_tready;
  assign bus.m_axis_tvalid = busy & sel_valid;
  assign bus.m_axis_tlast  = busy & pkt_last;
  assign bus.m_axis_tkeep  = busy ? sel_keep : 8'd0;
  assign bus.m_axis_tdata  = busy ? sel_data : '0;
`endif
endmodule
